// File: rtl/dmux_pkg.sv
// Shared types and constants for the dmux_dispatch slice: the two-state
// dispatcher FSM encoding and the width of the optional per-output counters.
package dmux_pkg;

   typedef enum logic {
      EMPTY = 1'b0,
      HOLD  = 1'b1
   } state_t;

   localparam int CNT_W = 16;

endpackage

// File: rtl/dmux_dispatch_rr_ptr.sv
// Modulo-NOUT round-robin pointer. It steps by one when adv is high, and
// load_zero returns it to output 0.
module rr_ptr #(
   parameter int NOUT  = 4,
   parameter int SEL_W = $clog2(NOUT)
) (
   input  logic             clk,
   input  logic             adv,
   input  logic             load_zero,
   output logic [SEL_W-1:0] ptr
);

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // in the design samples the pre-edge values regardless of block ordering.
   always_ff @(posedge clk) begin
      if (load_zero) begin
         ptr <= '0;
      end else if (adv) begin
         ptr <= (ptr == SEL_W'(NOUT - 1)) ? '0 : ptr + 1'b1;
      end
   end

endmodule

// File: rtl/dmux_dispatch.sv
// One-entry dispatcher that steers each upstream item to one of NOUT outputs,
// using either round-robin or fixed steering. Defining DMUX_DISPATCH_CNT_EN
// adds a 16-bit transfer counter for each output, exposed on the dcount port.
module dmux_dispatch
   import dmux_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int NOUT  = 4,
   localparam int SEL_W = $clog2(NOUT)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             mode,
   input  logic [SEL_W-1:0] fixed_sel,
   output logic [NOUT-1:0]  out_valid,
   input  logic [NOUT-1:0]  out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [SEL_W-1:0] cur_sel,
   output logic             busy
`ifdef DMUX_DISPATCH_CNT_EN
   ,output logic [NOUT*CNT_W-1:0] dcount
`endif
);

   state_t           state_q;
   logic [SEL_W-1:0] target_q;
   logic [SEL_W-1:0] rr_val;
   logic [SEL_W-1:0] nxt_tgt;
   logic [NOUT-1:0]  nxt_onehot;
   logic             accept;
   logic             xfer;

   // While a transfer is in progress, the held slot frees up in the same cycle,
   // so a new item can follow on the next cycle without a gap.
   assign in_ready   = rst_n & ((state_q == EMPTY) | out_ready[target_q]);
   assign accept     = in_valid & in_ready;
   assign xfer       = (state_q == HOLD) & out_ready[target_q];
   assign nxt_tgt    = mode ? fixed_sel : rr_val;
   assign nxt_onehot = {{(NOUT-1){1'b0}}, 1'b1} << nxt_tgt;
   assign cur_sel    = (state_q == HOLD) ? target_q : rr_val;

   rr_ptr #(
      .NOUT  (NOUT),
      .SEL_W (SEL_W)
   ) u_rr_ptr (
      .clk       (clk),
      .adv       (accept & ~mode),
      .load_zero (~rst_n),
      .ptr       (rr_val)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= EMPTY;
         target_q  <= '0;
         out_data  <= '0;
         out_valid <= '0;
         busy      <= 1'b0;
      end else begin
         case (state_q)
            EMPTY: begin
               if (accept) begin
                  state_q   <= HOLD;
                  target_q  <= nxt_tgt;
                  out_data  <= in_data;
                  out_valid <= nxt_onehot;
                  busy      <= 1'b1;
               end
            end
            HOLD: begin
               if (accept) begin
                  target_q  <= nxt_tgt;
                  out_data  <= in_data;
                  out_valid <= nxt_onehot;
               end else if (xfer) begin
                  // The last value stays on out_data, but no output is marked valid.
                  state_q   <= EMPTY;
                  out_valid <= '0;
                  busy      <= 1'b0;
               end
            end
            default: state_q <= EMPTY;
         endcase
      end
   end

`ifdef DMUX_DISPATCH_CNT_EN
   logic [CNT_W-1:0] cnt_q [NOUT];

   always_ff @(posedge clk) begin
      for (int i = 0; i < NOUT; i++) begin
         if (!rst_n) begin
            cnt_q[i] <= '0;
         end else if (xfer && (target_q == SEL_W'(i))) begin
            cnt_q[i] <= cnt_q[i] + 1'b1;
         end
      end
   end

   for (genvar g = 0; g < NOUT; g++) begin : g_dcount
      assign dcount[g*CNT_W +: CNT_W] = cnt_q[g];
   end
`endif

endmodule

// File: tb/tb_dmux_dispatch.sv
// Directed, self-checking bench for dmux_dispatch (WIDTH=8, NOUT=4). It steps
// through a table of cycle-by-cycle vectors, then runs hand-written sequences.
module tb_dmux_dispatch;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_data;
   logic        mode;
   logic [1:0]  fixed_sel;
   logic [3:0]  out_valid;
   logic [3:0]  out_ready;
   logic [7:0]  out_data;
   logic [1:0]  cur_sel;
   logic        busy;
`ifdef DMUX_DISPATCH_CNT_EN
   logic [63:0] dcount;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   dmux_dispatch #(.WIDTH(8), .NOUT(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .mode      (mode),
      .fixed_sel (fixed_sel),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .cur_sel   (cur_sel),
      .busy      (busy)
`ifdef DMUX_DISPATCH_CNT_EN
      ,.dcount   (dcount)
`endif
   );

   // Inputs are applied for one cycle. Expected outputs describe the DUT just
   // before the rising edge that consumes those inputs.
   typedef struct {
      logic       rst_n;
      logic       in_valid;
      logic [7:0] in_data;
      logic       mode;
      logic [1:0] fixed_sel;
      logic [3:0] out_ready;
      logic       exp_in_ready;
      logic [3:0] exp_out_valid;
      logic [7:0] exp_out_data;
      logic [1:0] exp_cur_sel;
      logic       exp_busy;
   } vec_t;

   vec_t vecs [17];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Rows 1-9: round-robin back-to-back stream (0x10..0x17), wrapping at 3.
      // Rows 10-16: fixed steering to output 2, then back to round-robin.
      //            rst in_v data   md sel ready   | ir  ov    data   cur busy
      vecs[0]  = '{1'b0, 1'b1, 8'h99, 1'b0, 2'd0, 4'hF, 1'b0, 4'b0000, 8'h00, 2'd0, 1'b0};
      vecs[1]  = '{1'b1, 1'b1, 8'h10, 1'b0, 2'd0, 4'hF, 1'b1, 4'b0000, 8'h00, 2'd0, 1'b0};
      vecs[2]  = '{1'b1, 1'b1, 8'h11, 1'b0, 2'd0, 4'hF, 1'b1, 4'b0001, 8'h10, 2'd0, 1'b1};
      vecs[3]  = '{1'b1, 1'b1, 8'h12, 1'b0, 2'd0, 4'hF, 1'b1, 4'b0010, 8'h11, 2'd1, 1'b1};
      vecs[4]  = '{1'b1, 1'b1, 8'h13, 1'b0, 2'd0, 4'hF, 1'b1, 4'b0100, 8'h12, 2'd2, 1'b1};
      vecs[5]  = '{1'b1, 1'b1, 8'h14, 1'b0, 2'd0, 4'hF, 1'b1, 4'b1000, 8'h13, 2'd3, 1'b1};
      vecs[6]  = '{1'b1, 1'b1, 8'h15, 1'b0, 2'd0, 4'hF, 1'b1, 4'b0001, 8'h14, 2'd0, 1'b1};
      vecs[7]  = '{1'b1, 1'b1, 8'h16, 1'b0, 2'd0, 4'hF, 1'b1, 4'b0010, 8'h15, 2'd1, 1'b1};
      vecs[8]  = '{1'b1, 1'b1, 8'h17, 1'b0, 2'd0, 4'hF, 1'b1, 4'b0100, 8'h16, 2'd2, 1'b1};
      vecs[9]  = '{1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 4'hF, 1'b1, 4'b1000, 8'h17, 2'd3, 1'b1};
      vecs[10] = '{1'b1, 1'b1, 8'h20, 1'b0, 2'd0, 4'hF, 1'b1, 4'b0000, 8'h17, 2'd0, 1'b0};
      vecs[11] = '{1'b1, 1'b1, 8'h30, 1'b1, 2'd2, 4'hF, 1'b1, 4'b0001, 8'h20, 2'd0, 1'b1};
      vecs[12] = '{1'b1, 1'b1, 8'h31, 1'b1, 2'd2, 4'hF, 1'b1, 4'b0100, 8'h30, 2'd2, 1'b1};
      vecs[13] = '{1'b1, 1'b1, 8'h32, 1'b1, 2'd2, 4'hF, 1'b1, 4'b0100, 8'h31, 2'd2, 1'b1};
      vecs[14] = '{1'b1, 1'b1, 8'h40, 1'b0, 2'd0, 4'hF, 1'b1, 4'b0100, 8'h32, 2'd2, 1'b1};
      vecs[15] = '{1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 4'hF, 1'b1, 4'b0010, 8'h40, 2'd1, 1'b1};
      vecs[16] = '{1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 4'hF, 1'b1, 4'b0000, 8'h40, 2'd2, 1'b0};

      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; mode = 1'b0;
      fixed_sel = '0; out_ready = '0;
      next_cycle();
      next_cycle();

      for (int i = 0; i < 17; i++) begin
         rst_n     = vecs[i].rst_n;
         in_valid  = vecs[i].in_valid;
         in_data   = vecs[i].in_data;
         mode      = vecs[i].mode;
         fixed_sel = vecs[i].fixed_sel;
         out_ready = vecs[i].out_ready;
         @(negedge clk);
         check($sformatf("row%0d in_ready", i),  32'(in_ready),  32'(vecs[i].exp_in_ready));
         check($sformatf("row%0d out_valid", i), 32'(out_valid), 32'(vecs[i].exp_out_valid));
         check($sformatf("row%0d out_data", i),  32'(out_data),  32'(vecs[i].exp_out_data));
         check($sformatf("row%0d cur_sel", i),   32'(cur_sel),   32'(vecs[i].exp_cur_sel));
         check($sformatf("row%0d busy", i),      32'(busy),      32'(vecs[i].exp_busy));
         next_cycle();
      end

      // Backpressure: 0xA5 is held for output 1 while output 0 is ready and ignored.
      // The round-robin pointer is 2 at this point.
      in_valid = 1'b1; in_data = 8'hA5; mode = 1'b1; fixed_sel = 2'd1; out_ready = 4'hF;
      next_cycle();
      in_data = 8'hBB; mode = 1'b0; fixed_sel = 2'd0; out_ready = 4'b1101;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check($sformatf("bp%0d in_ready", c),  32'(in_ready),  32'h0);
         check($sformatf("bp%0d out_data", c),  32'(out_data),  32'hA5);
         check($sformatf("bp%0d out_valid", c), 32'(out_valid), 32'b0010);
         next_cycle();
      end
      out_ready = 4'hF;
      @(negedge clk);
      check("bp release in_ready", 32'(in_ready), 32'h1);
      next_cycle();
      in_valid = 1'b0;
      @(negedge clk);
      check("bp next out_valid", 32'(out_valid), 32'b0100);
      check("bp next out_data",  32'(out_data),  32'hBB);
      check("bp next cur_sel",   32'(cur_sel),   32'd2);
      next_cycle();
      @(negedge clk);
      check("bp drained busy",   32'(busy),      32'h0);
      check("bp rr at 3",        32'(cur_sel),   32'd3);

      // Reset while an item is held: the item is dropped and never delivered.
      in_valid = 1'b1; in_data = 8'hC7; out_ready = 4'h0;
      next_cycle();
      in_valid = 1'b0;
      @(negedge clk);
      check("rst pre out_valid", 32'(out_valid), 32'b1000);
      check("rst pre cur_sel",   32'(cur_sel),   32'd3);
      rst_n = 1'b0; out_ready = 4'hF;
      @(negedge clk);
      check("rst in_ready low",  32'(in_ready),  32'h0);
      next_cycle();
      rst_n = 1'b1;
      @(negedge clk);
      check("rst post out_valid", 32'(out_valid), 32'h0);
      check("rst post busy",      32'(busy),      32'h0);
      check("rst post cur_sel",   32'(cur_sel),   32'd0);
      check("rst post out_data",  32'(out_data),  32'h0);
      for (int c = 0; c < 3; c++) begin
         next_cycle();
         @(negedge clk);
         check($sformatf("rst idle%0d out_valid", c), 32'(out_valid), 32'h0);
      end
      next_cycle();

`ifdef DMUX_DISPATCH_CNT_EN
      // Send 65535 items to output 3, then one more; the counter wraps to zero.
      rst_n = 1'b0;
      next_cycle();
      rst_n = 1'b1; in_valid = 1'b1; mode = 1'b1; fixed_sel = 2'd3; out_ready = 4'hF;
      for (int k = 0; k < 65535; k++) next_cycle();
      in_valid = 1'b0;
      next_cycle();
      @(negedge clk);
      check("cnt3 at ffff", 32'(dcount[48 +: 16]), 32'hFFFF);
      check("cnt0 idle",    32'(dcount[0 +: 16]),  32'h0);
      in_valid = 1'b1;
      next_cycle();
      in_valid = 1'b0;
      next_cycle();
      @(negedge clk);
      check("cnt3 wrapped", 32'(dcount[48 +: 16]), 32'h0);
      next_cycle();
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/dmux_dispatch.md
DMUX_DISPATCH -- requirements
Module: dmux_dispatch

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data bit width.
REQ-002 SHALL have parameter NOUT, default 4, number of outputs; power of two, 2..16.
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; synchronous and active-low.
REQ-005 SHALL have port in_valid  input  1  upstream item present.
REQ-006 SHALL have port in_ready  output  1  dispatcher can accept an item this cycle.
REQ-007 SHALL have port in_data  input  WIDTH  upstream item.
REQ-008 SHALL have port mode  input  1  0 = round-robin steering, 1 = fixed steering.
REQ-009 SHALL have port fixed_sel  input  log2(NOUT)  target output in fixed mode.
REQ-010 SHALL have port out_valid  output  NOUT  one-hot valid, one bit per output.
REQ-011 SHALL have port out_ready  input  NOUT  per-output downstream ready.
REQ-012 SHALL have port out_data  output  WIDTH  shared data bus to all outputs.
REQ-013 SHALL have port cur_sel  output  log2(NOUT)  target of the held item (round-robin pointer when empty).
REQ-014 SHALL have port busy  output  1  holding register occupied.

Function
REQ-015 SHALL use a two-state FSM: EMPTY and HOLD.
REQ-016 SHALL drive in_ready = (state==EMPTY) | out_ready[target]: combinational, full throughput.
REQ-017 SHALL, on in_valid & in_ready, capture in_data and target = mode ? fixed_sel : rr_ptr, then enter or stay in HOLD.
REQ-018 SHALL sample mode and fixed_sel only at acceptance; later changes SHALL NOT affect a held item.
REQ-019 SHALL, in HOLD, assert only out_valid[target]; all other out_valid bits SHALL be 0; in EMPTY, out_valid SHALL be all-zero.
REQ-020 SHALL give latency of one cycle from acceptance to out_valid; out_data SHALL hold the captured value stable until transfer.
REQ-021 SHALL complete a transfer on out_valid[target] & out_ready[target]; out_ready on non-target outputs SHALL be ignored.
REQ-022 SHALL, on transfer with no simultaneous acceptance, return to EMPTY.
REQ-023 SHALL, on simultaneous transfer and acceptance, stay in HOLD with the new item and no bubble.
REQ-024 SHALL advance rr_ptr to (target+1) mod NOUT on acceptance in round-robin mode only, wrapping NOUT-1 -> 0; fixed-mode acceptances SHALL leave rr_ptr unchanged.
REQ-025 SHALL assert busy exactly when state==HOLD.

Reset
REQ-026 SHALL, when rst_n=0 at a clock edge, force: state EMPTY, rr_ptr 0, out_valid 0, out_data 0, busy 0, cur_sel 0.
REQ-027 SHALL discard a held item on reset mid-operation; no transfer SHALL occur in the reset cycle.
REQ-028 SHALL hold in_ready at 0 while rst_n=0.

Configuration
REQ-029 SHALL, with DMUX_DISPATCH_CNT_EN defined, add output dcount (NOUT*16 bits): per-output 16-bit transfer counters, incremented on each transfer, wrapping 0xFFFF -> 0, cleared by reset.
REQ-030 SHALL, without DMUX_DISPATCH_CNT_EN, omit the dcount port and the counter logic entirely.

Structure
REQ-031 SHALL place the FSM state typedef (EMPTY/HOLD) and the counter width constant (16) in shared package dmux_pkg.
REQ-032 SHALL instantiate one sub-module, rr_ptr: a modulo-NOUT pointer with an advance-enable input and a load-to-zero input.

Verification
REQ-033 Round-robin, all out_ready=1, 8 back-to-back items 0x10..0x17 SHALL appear on outputs 0,1,2,3,0,1,2,3, one per cycle after a 1-cycle latency.
REQ-034 Fixed mode, fixed_sel=2, 3 items: only out_valid[2] SHALL assert; rr_ptr SHALL stay unchanged; then switching mode=0 SHALL send the next item to the prior rr_ptr.
REQ-035 Backpressure: hold item 0xA5 for output 1 with out_ready[1]=0 for 5 cycles and out_ready[0]=1: out_data SHALL remain 0xA5, in_ready=0, and no transfer SHALL occur until out_ready[1]=1.
REQ-036 Reset mid-HOLD: rst_n=0 for 1 cycle with item held: the next cycle SHALL show out_valid=0, busy=0, cur_sel=0, and the item SHALL never be delivered.
REQ-037 Wrap: starting with rr_ptr=3, accept one item: cur_sel SHALL be 3 and the next target SHALL be 0; with DMUX_DISPATCH_CNT_EN, output-3 counter preset near 0xFFFF SHALL wrap to 0.
